uart_tx_queue: RTL and testbench

//  Byte FIFO placed directly upstream of uart_tx. Producers push bytes at

---
 rtl/uart_tx_queue.sv | 115 +++++++++++
 tb/tb_uart_tx_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding uart_tx through its start_write /
// write_data / write_avl handshake, so producers never wait on frame time.
// DEPTH = 2**ADDR_W entries.
// Optional feature macro: UART_TXQ_OVERFLOW_EN
//   defined     -> sticky overflow flag, set by any push while full
//   not defined -> overflow tied low; dropping of pushes is unchanged
module uart_tx_queue #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [7:0]        push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              start_write,
    output logic [7:0]        write_data,
    input  logic              write_avl
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Status comes from the registered level, so full is the pre-edge value
    // and a push while full is dropped even when a pop happens the same cycle.
    assign full    = (level == (ADDR_W + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = (state == IDLE) && !empty && write_avl;

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy counter; simultaneous push and pop leave level unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (ADDR_W + 1)'(1);
                2'b01:   level <= level - (ADDR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // FSM state register plus registered launch outputs; the pop loads write_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_write <= 1'b0;
            write_data  <= '0;
        end else begin
            state       <= state_nx;
            start_write <= do_pop;
            if (do_pop) begin
                write_data <= mem[rd_ptr];
            end
        end
    end

    // Next-state logic for the uart_tx handshake.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (do_pop)     state_nx = LAUNCH;
            LAUNCH:                    state_nx = WAIT_BUSY;
            WAIT_BUSY: if (!write_avl) state_nx = WAIT_DONE;
            WAIT_DONE: if (write_avl)  state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

`ifdef UART_TXQ_OVERFLOW_EN
    // Sticky flag: any push seen while full, held until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed scenarios followed by random traffic,
// checked against a queue-based model and a simple uart_tx responder.
module tb_uart_tx_queue;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              push = 1'b0;
    logic [7:0]        push_data = '0;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              start_write;
    logic [7:0]        write_data;
    logic              write_avl = 1'b1;

    uart_tx_queue #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_data   (push_data),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .start_write (start_write),
        .write_data  (write_data),
        .write_avl   (write_avl)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mq[$];          // bytes accepted but not yet handed over
    logic [7:0]  rx[$];          // bytes seen at each strobe
    int          stage = 0;      // 0 free, 1 strobe cycle, 2 awaiting accept, 3 awaiting frame end
    logic [7:0]  m_wd = '0;
    bit          m_ovf = 1'b0;
    int          u_left = 0;
    bit          avl_idle = 1'b1;
    int          frame_len = 3;
    int          strobes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit exp_ovf;
`ifdef UART_TXQ_OVERFLOW_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = 1'b0;
`endif
        check({tag, "_level"}, 32'(level), 32'(mq.size()));
        check({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        check({tag, "_start_write"}, 32'(start_write), 32'(stage == 1));
        check({tag, "_write_data"}, 32'(write_data), 32'(m_wd));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // One clock: drive inputs, advance the model, check, then run the uart_tx responder.
    task automatic step(input bit p, input logic [7:0] d);
        bit was_full;
        bit acc;
        bit pop;
        push      = p;
        push_data = d;
        was_full  = (mq.size() == DEPTH);
        acc       = p && !was_full;
        pop       = (stage == 0) && (mq.size() != 0) && write_avl;
        @(posedge clk);
        if (p && was_full) m_ovf = 1'b1;
        case (stage)
            1:       stage = 2;
            2:       if (!write_avl) stage = 3;
            3:       if (write_avl) stage = 0;
            default: ;
        endcase
        if (pop) begin
            m_wd  = mq.pop_front();
            stage = 1;
        end
        if (acc) mq.push_back(d);
        #1;
        check_outputs("step");
        if (start_write) begin
            strobes++;
            rx.push_back(write_data);
            u_left = frame_len;
        end else if (u_left > 0) begin
            write_avl = 1'b0;
            u_left--;
        end else begin
            write_avl = avl_idle;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        avl_idle = 1'b1;
        while ((mq.size() != 0 || stage != 0 || u_left != 0) && n < 400) begin
            step(1'b0, 8'h00);
            n++;
        end
        check({tag, "_drain_bound"}, 32'(n < 400), 32'd1);
    endtask

    // Asynchronous reset asserted between clock edges, released on a falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_start_write"}, 32'(start_write), 32'd0);
        check({tag, "_rst_level"}, 32'(level), 32'd0);
        check({tag, "_rst_empty"}, 32'(empty), 32'd1);
        mq.delete();
        stage     = 0;
        m_wd      = '0;
        m_ovf     = 1'b0;
        u_left    = 0;
        avl_idle  = 1'b1;
        write_avl = 1'b1;
        push      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int s0;
        int n;
        bit saw55;

        // Reset state
        #2;
        do_reset("reset");
        check_outputs("after_reset");
        check("reset_write_data", 32'(write_data), 32'h00);
        check("reset_full", 32'(full), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        // Single byte: strobe exactly two cycles after the push cycle
        s0 = strobes;
        step(1'b1, 8'hA5);
        check("single_no_bypass", 32'(start_write), 32'd0);
        check("single_level1", 32'(level), 32'd1);
        step(1'b0, 8'h00);
        check("single_strobe", 32'(start_write), 32'd1);
        check("single_data", 32'(write_data), 32'hA5);
        drain("single");
        check("single_strobe_count", 32'(strobes - s0), 32'd1);
        check("single_empty", 32'(empty), 32'd1);

        // Burst 01..10 delivered in order, one strobe each
        s0 = strobes;
        rx.delete();
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i));
        drain("burst");
        check("burst_count", 32'(strobes - s0), 32'd16);
        for (int i = 0; i < 16 && i < rx.size(); i++)
            check("burst_order", 32'(rx[i]), 32'(i + 1));

        // Overflow: uart_tx held busy, 17 pushes, 17th dropped
        avl_idle  = 1'b0;
        write_avl = 1'b0;
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h20 + i));
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_full", 32'(full), 32'd1);
`ifdef UART_TXQ_OVERFLOW_EN
        check("ovf_flag", 32'(overflow), 32'd1);
`else
        check("ovf_flag", 32'(overflow), 32'd0);
`endif
        s0 = strobes;
        rx.delete();
        write_avl = 1'b1;
        drain("ovf");
        check("ovf_drain_count", 32'(strobes - s0), 32'd16);
        for (int i = 0; i < 16 && i < rx.size(); i++)
            check("ovf_drain_order", 32'(rx[i]), 32'(8'h20 + i));

        // Push while full on the pop cycle is dropped
        avl_idle  = 1'b0;
        write_avl = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i));
        avl_idle  = 1'b1;
        write_avl = 1'b1;
        s0 = strobes;
        rx.delete();
        step(1'b1, 8'h55);
        check("simul_full_level", 32'(level), 32'd15);
        check("simul_full_strobe", 32'(start_write), 32'd1);
        drain("simul_full");
        check("simul_full_count", 32'(strobes - s0), 32'd16);
        saw55 = 1'b0;
        foreach (rx[i]) if (rx[i] == 8'h55) saw55 = 1'b1;
        check("simul_full_no55", 32'(saw55), 32'd0);

        // Push and pop on the same edge at level 3
        avl_idle  = 1'b0;
        write_avl = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i));
        avl_idle  = 1'b1;
        write_avl = 1'b1;
        step(1'b1, 8'h66);
        check("simul_level3", 32'(level), 32'd3);
        check("simul_level3_strobe", 32'(start_write), 32'd1);
        drain("simul3");

        // Reset during the frame-wait phase with 5 bytes still queued
        avl_idle  = 1'b0;
        write_avl = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i));
        avl_idle  = 1'b1;
        write_avl = 1'b1;
        n = 0;
        while (stage != 3 && n < 50) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("midrst_reach_wait", 32'(n < 50), 32'd1);
        check("midrst_level5", 32'(level), 32'd5);
        #2;
        do_reset("midrst");
        s0 = strobes;
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00);
        check("midrst_no_strobes", 32'(strobes - s0), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);

        // Random traffic with varying uart_tx availability and frame length
        #2;
        do_reset("rand");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) avl_idle = ~avl_idle;
            frame_len = int'($urandom_range(1, 4));
            step(1'($urandom_range(0, 1)), 8'($urandom));
        end
        frame_len = 3;
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
